// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch redirect,
// data-memory wait and mul/div busy into per-stage write enables and bubble inserts.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ldUseStall,
  input  logic                 branchTaken,
  input  logic                 exmemMemReq,
  input  logic                 dmemReady,
  input  logic                 mulDivStart,
  input  logic                 mulDivDone,
  output logic                 pcWrite,
  output logic                 ifidWrite,
  output logic                 idexWrite,
  output logic                 exmemWrite,
  output logic                 memwbWrite,
  output logic                 ifidFlush,
  output logic                 idexFlush,
  output logic                 exmemFlush,
  output logic                 memError,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic [CNT_WIDTH-1:0] flushCount,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_BUSY  = 2'd2
  } state_t;

  localparam int TMO_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_SET = TMO_W'(MEM_TIMEOUT - 2);

  // Enable vector order: {pc, ifid, idex, exmem, memwb}; flush order: {ifid, idex, exmem}.
  localparam logic [4:0] WE_ALL  = 5'b11111;
  localparam logic [4:0] WE_NONE = 5'b00000;
  localparam logic [4:0] WE_MD   = 5'b00011;
  localparam logic [4:0] WE_LDU  = 5'b00111;

  state_t                 state_q, state_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

  logic [4:0] core_we, we;
  logic [2:0] core_fl, fl;
  state_t     core_next;
  logic       core_branch, branch_flush;

  // Branch / mul-div / load-use arbitration, shared by RUN and the MEM_WAIT release cycle.
  always_comb begin
    core_we     = WE_ALL;
    core_fl     = 3'b000;
    core_next   = ST_RUN;
    core_branch = 1'b0;
    if (branchTaken) begin
      core_fl     = 3'b110;
      core_branch = 1'b1;
    end else if (mulDivStart) begin
      core_we   = WE_MD;
      core_fl   = 3'b001;
      core_next = ST_MD_BUSY;
    end else if (ldUseStall) begin
      core_we = WE_LDU;
      core_fl = 3'b010;
    end
  end

  always_comb begin
    we           = WE_NONE;
    fl           = 3'b000;
    branch_flush = 1'b0;
    state_d      = state_q;
    tmo_d        = tmo_q;
    mem_err_d    = mem_err_q;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (exmemMemReq && !dmemReady) begin
            we      = WE_NONE;
            state_d = ST_MEM_WAIT;
            tmo_d   = '0;
          end else begin
            we           = core_we;
            fl           = core_fl;
            state_d      = core_next;
            branch_flush = core_branch;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmemReady) begin
            we = WE_NONE;
            if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
            // The RUN cycle that entered counts as the first not-ready cycle.
            if (tmo_q == TMO_SET) mem_err_d = 1'b1;
          end else begin
            we           = core_we;
            fl           = core_fl;
            state_d      = core_next;
            branch_flush = core_branch;
          end
        end
        ST_MD_BUSY: begin
          if (!mulDivDone) begin
            we = WE_MD;
            fl = 3'b001;
          end else begin
            we      = WE_ALL;
            state_d = ST_RUN;
          end
        end
        default: begin
          we      = WE_NONE;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!we[4])       stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (branch_flush) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite} = we;
  assign {ifidFlush, idexFlush, exmemFlush} = fl;
  assign memError    = mem_err_q;
  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: per-cycle expected outputs are queued by
// the driver and compared by a negedge monitor.
module tb_pipeline_stall_controller;

  localparam int CW = 32;
  localparam int W  = 2 + 5 + 3 + 1 + CW + CW;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_MD  = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic ldUseStall, branchTaken, exmemMemReq, dmemReady, mulDivStart, mulDivDone;
  logic pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite;
  logic ifidFlush, idexFlush, exmemFlush, memError;
  logic [CW-1:0] stallCycles, flushCount;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] tally_stall = '0;
  logic [CW-1:0] tally_flush = '0;

  pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .ldUseStall(ldUseStall), .branchTaken(branchTaken), .exmemMemReq(exmemMemReq),
    .dmemReady(dmemReady), .mulDivStart(mulDivStart), .mulDivDone(mulDivDone),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .exmemWrite(exmemWrite), .memwbWrite(memwbWrite),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
    .memError(memError), .stallCycles(stallCycles), .flushCount(flushCount),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: one call = one clock cycle. in = {ld, br, mreq, rdy, mds, mdd}.
  // Expected counters are the values visible during this cycle (before its closing edge).
  task automatic step(input string nm, input logic rst, input logic [5:0] in,
                      input logic [4:0] ew, input logic [2:0] ef, input logic em,
                      input logic [1:0] es);
    @(posedge clk);
    #1;
    reset = rst;
    {ldUseStall, branchTaken, exmemMemReq, dmemReady, mulDivStart, mulDivDone} = in;
    exp_q.push_back({es, ew, ef, em, tally_stall, tally_flush});
    name_q.push_back(nm);
    if (rst) begin
      tally_stall = '0;
      tally_flush = '0;
    end else begin
      if (!ew[4]) tally_stall = tally_stall + 1'b1;
      if (ef[2])  tally_flush = tally_flush + 1'b1;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {dbg_state, pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite,
            ifidFlush, idexFlush, exmemFlush, memError, stallCycles, flushCount};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d we=%b fl=%b merr=%b stall=%0d flush=%0d ; want st=%0d we=%b fl=%b merr=%b stall=%0d flush=%0d",
                 nm, a[W-1 -: 2], a[W-3 -: 5], a[W-8 -: 3], a[2*CW], a[2*CW-1 -: CW], a[CW-1:0],
                 e[W-1 -: 2], e[W-3 -: 5], e[W-8 -: 3], e[2*CW], e[2*CW-1 -: CW], e[CW-1:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    {ldUseStall, branchTaken, exmemMemReq, dmemReady, mulDivStart, mulDivDone} = 6'b0;
    repeat (2) @(posedge clk);

    // Idle after reset
    step("reset_hold", 1, 6'b000000, 5'b00000, 3'b000, 0, S_RUN);
    step("idle0",      0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);
    step("idle1",      0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);

    // Single-cycle load-use stall
    step("ldu",        0, 6'b100000, 5'b00111, 3'b010, 0, S_RUN);
    step("ldu_after",  0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);
    step("ldu_rst",    1, 6'b000000, 5'b00000, 3'b000, 0, S_RUN);

    // Branch overrides load-use
    step("br_ldu",     0, 6'b110000, 5'b11111, 3'b110, 0, S_RUN);
    step("br_after",   0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);
    step("br_rst",     1, 6'b000000, 5'b00000, 3'b000, 0, S_RUN);

    // Memory wait: 3 not-ready cycles then ready
    step("memreq_rdy", 0, 6'b001100, 5'b11111, 3'b000, 0, S_RUN);
    step("mem_nr1",    0, 6'b001000, 5'b00000, 3'b000, 0, S_RUN);
    step("mem_nr2",    0, 6'b001000, 5'b00000, 3'b000, 0, S_MW);
    step("mem_nr3",    0, 6'b001000, 5'b00000, 3'b000, 0, S_MW);
    step("mem_rdy",    0, 6'b001100, 5'b11111, 3'b000, 0, S_MW);
    step("mem_after",  0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);
    step("mem_rst",    1, 6'b000000, 5'b00000, 3'b000, 0, S_RUN);

    // Mul/div: done with start ignored, memreq ignored while busy, done 4 cycles later
    step("md_start",   0, 6'b000011, 5'b00011, 3'b001, 0, S_RUN);
    step("md_busy1",   0, 6'b000000, 5'b00011, 3'b001, 0, S_MD);
    step("md_busy2",   0, 6'b001000, 5'b00011, 3'b001, 0, S_MD);
    step("md_busy3",   0, 6'b000000, 5'b00011, 3'b001, 0, S_MD);
    step("md_done",    0, 6'b000011, 5'b11111, 3'b000, 0, S_MD);
    step("md_after",   0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);
    step("md_rst",     1, 6'b000000, 5'b00000, 3'b000, 0, S_RUN);

    // Release from MEM_WAIT into a branch, then into a mul/div
    step("mw_br_nr",   0, 6'b001000, 5'b00000, 3'b000, 0, S_RUN);
    step("mw_br_rdy",  0, 6'b011100, 5'b11111, 3'b110, 0, S_MW);
    step("mw_md_nr",   0, 6'b001000, 5'b00000, 3'b000, 0, S_RUN);
    step("mw_md_rdy",  0, 6'b001110, 5'b00011, 3'b001, 0, S_MW);
    step("mw_md_done", 0, 6'b000001, 5'b11111, 3'b000, 0, S_MD);
    step("mw_ldu",     0, 6'b100000, 5'b00111, 3'b010, 0, S_RUN);
    step("mw_after",   0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);

    // Reset aborts MD_BUSY
    step("abort_start", 0, 6'b000010, 5'b00011, 3'b001, 0, S_RUN);
    step("abort_rst",   1, 6'b000000, 5'b00000, 3'b000, 0, S_MD);
    step("abort_after", 0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);

    // Memory timeout: 16 not-ready cycles set memError, which is sticky until reset
    step("tmo_1", 0, 6'b001000, 5'b00000, 3'b000, 0, S_RUN);
    for (int i = 2; i <= 16; i++)
      step($sformatf("tmo_%0d", i), 0, 6'b001000, 5'b00000, 3'b000, 0, S_MW);
    step("tmo_set",   0, 6'b001000, 5'b00000, 3'b000, 1, S_MW);
    step("tmo_rdy",   0, 6'b001100, 5'b11111, 3'b000, 1, S_MW);
    step("tmo_stick", 0, 6'b000000, 5'b11111, 3'b000, 1, S_RUN);
    step("tmo_rst",   1, 6'b000000, 5'b00000, 3'b000, 1, S_RUN);
    step("tmo_clr",   0, 6'b000000, 5'b11111, 3'b000, 0, S_RUN);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries ; want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
